// File: rtl/seq_booth_multiplier_pkg.sv
// Shared types for the sequential radix-2 Booth multiplier.
// Optional signed/unsigned select is enabled by MULT_SIGN_SEL_EN.
package mult_pkg;

  localparam int STATE_W = 2;

  typedef enum logic [STATE_W-1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    DONE = 2'd2
  } state_e;

  // Counter must hold M = n+1, so it needs clog2(M+1) bits.
  function automatic int cnt_w(input int n);
    return $clog2(n + 2);
  endfunction

endpackage

// File: rtl/seq_booth_multiplier_if.sv
// Start/done handshake and operand bus of the Booth multiplier.
// The sgn signal exists only when MULT_SIGN_SEL_EN is defined.
interface seq_booth_multiplier_if #(
  parameter int N = 5
);

  logic           start;
  logic [N-1:0]   A;
  logic [N-1:0]   B;
`ifdef MULT_SIGN_SEL_EN
  logic           sgn;
`endif
  logic           ready;
  logic           busy;
  logic           done;
  logic [2*N-1:0] out;

  modport master (
`ifdef MULT_SIGN_SEL_EN
    output sgn,
`endif
    output start, A, B,
    input  ready, busy, done, out
  );

  modport slave (
`ifdef MULT_SIGN_SEL_EN
    input  sgn,
`endif
    input  start, A, B,
    output ready, busy, done, out
  );

endinterface

// File: rtl/seq_booth_multiplier_booth_step.sv
// One radix-2 Booth iteration: conditional add/sub of the
// multiplicand into P, then arithmetic right shift of {P,Q,q_1}.
module booth_step #(
  parameter int M = 6
) (
  input  logic [M-1:0] p_i,
  input  logic [M-1:0] q_i,
  input  logic         q1_i,
  input  logic [M-1:0] mcand_i,
  output logic [M-1:0] p_o,
  output logic [M-1:0] q_o,
  output logic         q1_o
);

  logic [M-1:0] sum;

  always_comb begin
    sum = p_i;
    unique case (1'b1)
      (q_i[0] & ~q1_i): sum = p_i - mcand_i;
      (~q_i[0] & q1_i): sum = p_i + mcand_i;
      default:          sum = p_i;
    endcase
  end

  assign {p_o, q_o, q1_o} = {sum[M-1], sum, q_i};

endmodule

// File: rtl/seq_booth_multiplier.sv
// Sequential radix-2 Booth multiplier, N x N -> 2N, N+2 cycle latency.
// Define MULT_SIGN_SEL_EN to add the sgn (signed/unsigned) select.
module seq_booth_multiplier #(
  parameter int N = 5
) (
  input  logic                  clk,
  input  logic                  rst,
  seq_booth_multiplier_if.slave bus
);

  import mult_pkg::*;

  localparam int M  = N + 1;
  localparam int CW = cnt_w(N);

  state_e         state_q;
  logic [M-1:0]   mcand_q;
  logic [M-1:0]   p_q;
  logic [M-1:0]   q_q;
  logic           q1_q;
  logic [CW-1:0]  cnt_q;
  logic           ready_q;
  logic           busy_q;
  logic           done_q;
  logic [2*N-1:0] out_q;

  logic [M-1:0]   p_d;
  logic [M-1:0]   q_d;
  logic           q1_d;
  logic           sx;
  logic [M-1:0]   a_ext;
  logic [M-1:0]   b_ext;

`ifdef MULT_SIGN_SEL_EN
  assign sx = bus.sgn;
`else
  assign sx = 1'b1;
`endif

  // Extra bit keeps min*min and unsigned operands in range.
  assign a_ext = {sx & bus.A[N-1], bus.A};
  assign b_ext = {sx & bus.B[N-1], bus.B};

  booth_step #(
    .M(M)
  ) u_step (
    .p_i    (p_q),
    .q_i    (q_q),
    .q1_i   (q1_q),
    .mcand_i(mcand_q),
    .p_o    (p_d),
    .q_o    (q_d),
    .q1_o   (q1_d)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      mcand_q <= '0;
      p_q     <= '0;
      q_q     <= '0;
      q1_q    <= 1'b0;
      cnt_q   <= '0;
      ready_q <= 1'b1;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      out_q   <= '0;
    end else begin
      done_q <= 1'b0;
      unique case (state_q)
        IDLE: begin
          if (bus.start) begin
            mcand_q <= a_ext;
            p_q     <= '0;
            q_q     <= b_ext;
            q1_q    <= 1'b0;
            cnt_q   <= CW'(M);
            ready_q <= 1'b0;
            busy_q  <= 1'b1;
            state_q <= CALC;
          end
        end
        CALC: begin
          p_q   <= p_d;
          q_q   <= q_d;
          q1_q  <= q1_d;
          cnt_q <= cnt_q - 1'b1;
          if (cnt_q == CW'(1)) begin
            busy_q  <= 1'b0;
            state_q <= DONE;
          end
        end
        DONE: begin
          out_q   <= {p_q[M-3:0], q_q};
          done_q  <= 1'b1;
          ready_q <= 1'b1;
          state_q <= IDLE;
        end
        default: begin
          ready_q <= 1'b1;
          busy_q  <= 1'b0;
          state_q <= IDLE;
        end
      endcase
    end
  end

  assign bus.ready = ready_q;
  assign bus.busy  = busy_q;
  assign bus.done  = done_q;
  assign bus.out   = out_q;

endmodule
